// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared state codes and helpers for the SRAM march BIST.
// Helpers work on 32-bit values; callers cast to ADDR_W/DATA_W (<= 32).
package sram_bist_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  function automatic logic [31:0] pass_start_addr(
    input logic        desc,
    input logic [31:0] last_addr
  );
    return desc ? last_addr : 32'd0;
  endfunction

  function automatic logic [31:0] pattern(
    input logic [31:0] addr,
    input logic        inv
  );
    return {32{inv}} ^ addr;
  endfunction

endpackage

// File: rtl/bist_read_pipe.sv
// bist_read_pipe: LATENCY-deep delay line of {valid, expected, address}.
// The head entry lines up with the SRAM read data for that address.
module bist_read_pipe #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_expected,
  input  logic [ADDR_W-1:0] push_address,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_expected,
  output logic [ADDR_W-1:0] head_address
);

  logic [LATENCY-1:0] valid_q;
  logic [DATA_W-1:0]  expected_q [LATENCY];
  logic [ADDR_W-1:0]  address_q  [LATENCY];

  // Shift one entry per cycle; reset empties the line.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        expected_q[i] <= '0;
        address_q[i]  <= '0;
      end
    end else begin
      valid_q[0]    <= push_valid;
      expected_q[0] <= push_expected;
      address_q[0]  <= push_address;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i]    <= valid_q[i-1];
        expected_q[i] <= expected_q[i-1];
        address_q[i]  <= address_q[i-1];
      end
    end
  end

  assign head_valid    = valid_q[LATENCY-1];
  assign head_expected = expected_q[LATENCY-1];
  assign head_address  = address_q[LATENCY-1];

endmodule

// File: rtl/sram_march_bist.sv
// sram_march_bist: multi-pass write/read march BIST for the external SRAM.
// Define SRAM_BIST_FAIL_CAPTURE_EN to latch the first failing address/data.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int LAST_ADDR    = 2**ADDR_W-1,
  parameter int READ_LATENCY = 2,
  parameter int NUM_PASSES   = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              BIST_start,
  output logic [ADDR_W-1:0] BIST_address,
  output logic [DATA_W-1:0] BIST_write_data,
  output logic              BIST_we_n,
  input  logic [DATA_W-1:0] BIST_read_data,
  output logic              BIST_finish,
  output logic              BIST_mismatch,
  output logic [ADDR_W-1:0] BIST_fail_address,
  output logic [DATA_W-1:0] BIST_fail_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
  localparam logic [1:0] FINAL_PASS  = 2'(NUM_PASSES-1);
  localparam logic [2:0] DRAIN_INIT  = 3'(READ_LATENCY);

  logic [1:0]        state;
  logic [1:0]        pass;
  logic [1:0]        next_pass;
  logic              start_buf;
  logic [2:0]        drain_cnt;
  logic              start_edge;
  logic              at_end;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] step_addr;
  logic [ADDR_W-1:0] cur_start;
  logic [ADDR_W-1:0] next_start;
  logic              head_valid;
  logic [DATA_W-1:0] head_expected;
  logic [ADDR_W-1:0] head_address;
  logic              cmp_fail;

  assign next_pass  = pass + 2'd1;
  assign start_edge = BIST_start & ~start_buf
                    & (state == S_IDLE);
  assign end_addr   = pass[0] ? '0 : LAST;
  assign at_end     = BIST_address == end_addr;
  assign step_addr  = pass[0]
                    ? BIST_address - ADDR_W'(1)
                    : BIST_address + ADDR_W'(1);
  assign cur_start  = ADDR_W'(pass_start_addr(
                        pass[0], 32'(LAST_ADDR)));
  assign next_start = ADDR_W'(pass_start_addr(
                        next_pass[0], 32'(LAST_ADDR)));

  assign BIST_write_data = DATA_W'(pattern(
                             32'(BIST_address), pass[1]));

  bist_read_pipe #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (READ_LATENCY)
  ) u_pipe (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .push_valid    (state == S_READ),
    .push_expected (BIST_write_data),
    .push_address  (BIST_address),
    .head_valid    (head_valid),
    .head_expected (head_expected),
    .head_address  (head_address)
  );

  assign cmp_fail = head_valid
                  & (BIST_read_data != head_expected);

  // Sweep sequencer: write sweep, read sweep, drain, next pass.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      pass         <= 2'd0;
      start_buf    <= 1'b0;
      drain_cnt    <= 3'd0;
      BIST_address <= '0;
      BIST_we_n    <= 1'b1;
      BIST_finish  <= 1'b0;
    end else begin
      start_buf <= BIST_start;
      unique case (state)
        S_IDLE: begin
          BIST_address <= '0;
          BIST_we_n    <= 1'b1;
          BIST_finish  <= 1'b1;
          if (start_edge) begin
            pass        <= 2'd0;
            BIST_finish <= 1'b0;
            BIST_we_n   <= 1'b0;
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (at_end) begin
            BIST_we_n    <= 1'b1;
            BIST_address <= cur_start;
            state        <= S_READ;
          end else begin
            BIST_address <= step_addr;
          end
        end
        S_READ: begin
          if (at_end) begin
            drain_cnt <= DRAIN_INIT;
            state     <= S_DRAIN;
          end else begin
            BIST_address <= step_addr;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 3'd1) begin
            if (pass == FINAL_PASS) begin
              BIST_finish  <= 1'b1;
              BIST_address <= '0;
              state        <= S_IDLE;
            end else begin
              pass         <= next_pass;
              BIST_address <= next_start;
              BIST_we_n    <= 1'b0;
              state        <= S_WRITE;
            end
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky mismatch, cleared only by an accepted start.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      BIST_mismatch <= 1'b0;
    end else if (start_edge) begin
      BIST_mismatch <= 1'b0;
    end else if (cmp_fail) begin
      BIST_mismatch <= 1'b1;
    end
  end

`ifdef SRAM_BIST_FAIL_CAPTURE_EN
  // Latch only the first failure since start.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      BIST_fail_address <= '0;
      BIST_fail_data    <= '0;
    end else if (start_edge) begin
      BIST_fail_address <= '0;
      BIST_fail_data    <= '0;
    end else if (cmp_fail && !BIST_mismatch) begin
      BIST_fail_address <= head_address;
      BIST_fail_data    <= BIST_read_data;
    end
  end
`else
  logic unused_head;
  assign unused_head       = ^head_address;
  assign BIST_fail_address = '0;
  assign BIST_fail_data    = '0;
`endif

endmodule

// File: tb/tb_sram_march_bist.sv
// tb_sram_march_bist: SRAM model with fault injection and a
// sweep-level reference model for the march BIST engine.
module tb_sram_march_bist;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int LA = 63;
  localparam int RL = 2;
  localparam int NP = 4;
  localparam int N  = LA + 1;
  localparam int P  = 2 * N + RL;

`ifdef SRAM_BIST_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  always #5 Clock = ~Clock;

  logic          start;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;
  logic          we_n;
  logic [DW-1:0] rd;
  logic          finish;
  logic          mm;
  logic [AW-1:0] fail_a;
  logic [DW-1:0] fail_d;

  logic          s_start;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wd;
  logic          s_we_n;
  logic [DW-1:0] s_rd;
  logic          s_finish;
  logic          s_mm;
  logic [AW-1:0] s_fail_a;
  logic [DW-1:0] s_fail_d;

  sram_march_bist #(
    .ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LA),
    .READ_LATENCY(RL), .NUM_PASSES(NP)
  ) dut (
    .Clock             (Clock),
    .Resetn            (Resetn),
    .BIST_start        (start),
    .BIST_address      (addr),
    .BIST_write_data   (wd),
    .BIST_we_n         (we_n),
    .BIST_read_data    (rd),
    .BIST_finish       (finish),
    .BIST_mismatch     (mm),
    .BIST_fail_address (fail_a),
    .BIST_fail_data    (fail_d)
  );

  sram_march_bist #(
    .ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(0),
    .READ_LATENCY(1), .NUM_PASSES(1)
  ) dut_small (
    .Clock             (Clock),
    .Resetn            (Resetn),
    .BIST_start        (s_start),
    .BIST_address      (s_addr),
    .BIST_write_data   (s_wd),
    .BIST_we_n         (s_we_n),
    .BIST_read_data    (s_rd),
    .BIST_finish       (s_finish),
    .BIST_mismatch     (s_mm),
    .BIST_fail_address (s_fail_a),
    .BIST_fail_data    (s_fail_d)
  );

  int tests = 0;
  int fails = 0;
  int gcyc = 0;
  int start_cyc = 0;

  logic [AW-1:0] f_addr = '0;
  int            f_bit = 0;
  int            f_kind = 0;
  logic [3:0]    f_mask = 4'h0;

  logic [DW-1:0] mem [N];
  logic [AW-1:0] hist [RL];
  logic [DW-1:0] s_mem;

  function automatic logic [DW-1:0] pat(
    input logic [AW-1:0] a, input int p);
    logic [DW-1:0] bg;
    bg = p[1] ? 16'hFFFF : 16'h0000;
    return bg ^ {{(DW-AW){1'b0}}, a};
  endfunction

  function automatic logic [DW-1:0] fault_fn(
    input logic [DW-1:0] v, input logic [AW-1:0] a,
    input int p, input logic [3:0] m,
    input logic [AW-1:0] fa, input int fb, input int fk);
    logic [DW-1:0] b;
    b = 16'd1 << fb;
    if (a != fa || !m[p]) return v;
    case (fk)
      0:       return v & ~b;
      1:       return v | b;
      default: return v ^ b;
    endcase
  endfunction

  // Reference: every pass writes then reads its sweep; the first
  // read that differs from the written background is the failure.
  task automatic model(
    input logic [AW-1:0] fa, input int fb, input int fk,
    input logic [3:0] fm, output logic emm,
    output logic [AW-1:0] ea, output logic [DW-1:0] ed);
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    logic [DW-1:0] v;
    emm = 1'b0; ea = '0; ed = '0;
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < N; i++) begin
        a = p[0] ? AW'(LA - i) : AW'(i);
        w = pat(a, p);
        v = fault_fn(w, a, p, fm, fa, fb, fk);
        if (v != w && !emm) begin
          emm = 1'b1; ea = a; ed = v;
        end
      end
    end
  endtask

  always @(posedge Clock) gcyc <= gcyc + 1;

  always @(posedge Clock) begin
    if (!we_n) mem[addr] <= wd;
    hist[0] <= addr;
    for (int i = 1; i < RL; i++) hist[i] <= hist[i-1];
    if (!s_we_n) s_mem <= s_wd;
  end

  always_comb begin
    int r;
    int p;
    r = gcyc - start_cyc;
    p = (r < 0) ? 0 : r / P;
    if (p > 3) p = 3;
    rd = fault_fn(mem[hist[RL-1]], hist[RL-1], p,
                  f_mask, f_addr, f_bit, f_kind);
  end

  assign s_rd = s_mem;

  task automatic check(input string name,
    input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Start a run and follow it cycle by cycle until finish,
  // counting deviations from the expected address/we_n/data walk.
  task automatic run_test(input bit restart,
    output int cycles, output int serr);
    int r, p, o;
    logic [AW-1:0] ea;
    logic          ew;
    @(negedge Clock);
    start = 1'b1;
    start_cyc = gcyc + 1;
    cycles = -1;
    serr = 0;
    for (int k = 0; k < 4 * P + 50; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      r = gcyc - start_cyc;
      if (r == 0) start = 1'b0;
      if (restart && r == N + 5) start = 1'b1;
      if (restart && r == N + 6) start = 1'b0;
      if (finish) begin
        cycles = r;
        break;
      end
      p = r / P;
      o = r % P;
      ew = (o >= N);
      if (o < N)
        ea = p[0] ? AW'(LA - o) : AW'(o);
      else if (o < 2 * N)
        ea = p[0] ? AW'(LA - (o - N)) : AW'(o - N);
      else
        ea = p[0] ? AW'(0) : AW'(LA);
      if (p >= NP || we_n !== ew || addr !== ea
          || wd !== pat(ea, p))
        serr++;
    end
    start = 1'b0;
  endtask

  task automatic fault_run(input string tag,
    input logic [AW-1:0] fa, input int fb, input int fk,
    input logic [3:0] fm, input logic emm,
    input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    int cyc, serr;
    f_addr = fa; f_bit = fb; f_kind = fk; f_mask = fm;
    run_test(1'b0, cyc, serr);
    check({tag, " cycles"}, cyc, 4 * P);
    check({tag, " walk"}, serr, 0);
    check({tag, " mismatch"}, 32'(mm), 32'(emm));
    check({tag, " fail_addr"}, 32'(fail_a),
          CAP ? 32'(ea) : 32'd0);
    check({tag, " fail_data"}, 32'(fail_d),
          CAP ? 32'(ed) : 32'd0);
    f_mask = 4'h0;
  endtask

  typedef struct {
    logic [AW-1:0] fa;
    int            fb;
    int            fk;
    logic [3:0]    fm;
    logic          emm;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vt [7];

  initial begin
    int cyc, serr, r, nw;
    logic          emm;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [AW-1:0] fa;
    int            fb, fk;
    logic [3:0]    fm;

    // kind: 0 stuck-at-0, 1 stuck-at-1, 2 flip
    vt[0] = '{6'd5,  3,  0, 4'hF, 1'b1, 6'd5,  16'hFFF2};
    vt[1] = '{6'd0,  0,  0, 4'h0, 1'b0, 6'd0,  16'h0000};
    vt[2] = '{6'd63, 0,  2, 4'h4, 1'b1, 6'd63, 16'hFFC1};
    vt[3] = '{6'd0,  15, 1, 4'hF, 1'b1, 6'd0,  16'h8000};
    vt[4] = '{6'd10, 7,  2, 4'h2, 1'b1, 6'd10, 16'h008A};
    vt[5] = '{6'd40, 5,  0, 4'h8, 1'b0, 6'd0,  16'h0000};
    vt[6] = '{6'd40, 4,  0, 4'h8, 1'b1, 6'd40, 16'hFFC7};

    start = 1'b0;
    s_start = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst finish", 32'(finish), 0);
    check("rst mismatch", 32'(mm), 0);
    check("rst we_n", 32'(we_n), 1);
    check("rst address", 32'(addr), 0);
    check("rst wdata", 32'(wd), 0);
    check("rst fail", {fail_a, fail_d}, 0);
    check("rst small", {s_finish, s_mm, s_we_n}, 1);

    Resetn = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    check("finish after reset", 32'(finish), 1);

    run_test(1'b0, cyc, serr);
    check("clean cycles", cyc, 4 * P);
    check("clean walk", serr, 0);
    check("clean mismatch", 32'(mm), 0);

    for (int i = 0; i < 7; i++)
      fault_run($sformatf("vec%0d", i), vt[i].fa, vt[i].fb,
                vt[i].fk, vt[i].fm, vt[i].emm,
                vt[i].ea, vt[i].ed);

    for (int i = 0; i < 6; i++) begin
      fa = AW'($urandom_range(0, LA));
      fb = int'($urandom_range(0, DW - 1));
      fk = int'($urandom_range(0, 2));
      fm = 4'($urandom_range(1, 15));
      model(fa, fb, fk, fm, emm, ea, ed);
      fault_run($sformatf("rnd%0d", i), fa, fb, fk, fm,
                emm, ea, ed);
    end

    run_test(1'b1, cyc, serr);
    check("restart cycles", cyc, 4 * P);
    check("restart walk", serr, 0);
    check("restart mismatch", 32'(mm), 0);

    f_addr = '0; f_bit = 15; f_kind = 1; f_mask = 4'hF;
    @(negedge Clock);
    start = 1'b1;
    start_cyc = gcyc + 1;
    r = 0;
    for (int k = 0; k < P + 40 && r < P + 20; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      r = gcyc - start_cyc;
      if (r == 0) start = 1'b0;
    end
    start = 1'b0;
    check("pre-abort mismatch", 32'(mm), 1);
    Resetn = 1'b0;
    #1;
    check("abort we_n", 32'(we_n), 1);
    check("abort address", 32'(addr), 0);
    check("abort finish", 32'(finish), 0);
    check("abort mismatch", 32'(mm), 0);
    check("abort fail", {fail_a, fail_d}, 0);
    f_mask = 4'h0;
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    check("abort finish after release", 32'(finish), 1);

    @(negedge Clock);
    s_start = 1'b1;
    cyc = -1;
    nw = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      s_start = 1'b0;
      if (s_finish) begin
        cyc = k;
        break;
      end
      if (!s_we_n) nw++;
      if (s_addr != '0) nw += 100;
    end
    check("small cycles", cyc, 3);
    check("small writes", nw, 1);
    check("small mismatch", 32'(s_mm), 0);
    check("small fail", {s_fail_a, s_fail_d}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
